axi_lite_cmd_master: RTL and testbench

AXI_LITE_CMD_MASTER -- requirements
Module: axi_lite_cmd_master

---
 rtl/axi_lite_cmd_master.sv | 194 +++++++++++++++++++
 tb/tb_axi_lite_cmd_master.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_cmd_master.sv
// AXI-Lite command master.
// Turns single read/write commands into AXI-Lite transactions and returns one
// response per command. Only one transaction is in flight at a time. A
// saturating wait counter raises `timeout` when a transaction stalls, but the
// transaction itself keeps waiting for the slave.
module axi_lite_cmd_master #(
  parameter int P_M_AXI_ADDR_WIDTH = 16,
  parameter int P_M_AXI_DATA_WIDTH = 32,
  parameter int P_TIMEOUT          = 1023
) (
  input  logic                          clock,
  input  logic                          reset,

  // Command / response side
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [P_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [P_M_AXI_DATA_WIDTH-1:0] cmd_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [P_M_AXI_DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          timeout,

  // AXI-Lite write address channel
  output logic [P_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  // AXI-Lite write data channel
  output logic [P_M_AXI_DATA_WIDTH-1:0] m_axi_wdata,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  // AXI-Lite write response channel
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  // AXI-Lite read address channel
  output logic [P_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  // AXI-Lite read data channel
  input  logic [P_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RESP
  } state_t;

  // Counter wide enough to hold P_TIMEOUT; it saturates at all-ones.
  localparam int              CNT_W     = (P_TIMEOUT < 1) ? 1 : $clog2(P_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(P_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_inc;
  logic             cmd_accept;
  logic             aw_done;
  logic             w_done;
  logic             waiting;

  // cmd_ready is only ever high in IDLE, so this is the acceptance strobe.
  assign cmd_accept   = cmd_valid & cmd_ready;

  // A channel is finished once its valid has dropped or is handshaking now.
  assign aw_done      = ~m_axi_awvalid | m_axi_awready;
  assign w_done       = ~m_axi_wvalid  | m_axi_wready;

  // States in which the transaction is waiting on the slave.
  assign waiting      = (state == WR)      || (state == WR_RESP) ||
                        (state == RD_ADDR) || (state == RD_DATA);

  assign wait_cnt_inc = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CNT_W'(1);

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
    end else begin
      // NOTE: state registers use non-blocking (<=) so every branch reads the
      // pre-edge values; blocking assignments here would make results depend
      // on statement order.
      unique case (state)
        IDLE: begin
          // cmd_ready rises one cycle after entering IDLE, so a command that
          // was already pending during the RESP handshake waits for it.
          if (!cmd_ready) begin
            cmd_ready <= 1'b1;
          end else if (cmd_valid) begin
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              m_axi_awaddr  <= cmd_addr;
              m_axi_wdata   <= cmd_wdata;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= WR;
            end else begin
              m_axi_araddr  <= cmd_addr;
              m_axi_arvalid <= 1'b1;
              state         <= RD_ADDR;
            end
          end
        end

        WR: begin
          // AW and W retire independently, in any order.
          if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid  && m_axi_wready)  m_axi_wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            m_axi_bready <= 1'b1;
            state        <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            rsp_resp     <= m_axi_bresp;
            rsp_rdata    <= '0;
            rsp_valid    <= 1'b1;
            state        <= RESP;
          end
        end

        RD_ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rsp_rdata    <= m_axi_rdata;
            rsp_resp     <= m_axi_rresp;
            rsp_valid    <= 1'b1;
            state        <= RESP;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Stall counter and sticky timeout flag for the current transaction.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else if (cmd_accept) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else if (waiting) begin
      wait_cnt <= wait_cnt_inc;
      if (wait_cnt_inc >= CNT_LIMIT) timeout <= 1'b1;
    end else if ((state == RESP) && rsp_valid && rsp_ready) begin
      timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master with a small behavioural AXI-Lite
// slave whose per-channel wait states are set by the stimulus thread.
module tb_axi_lite_cmd_master;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        timeout;

  logic [15:0] m_axi_awaddr;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [15:0] m_axi_araddr;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  axi_lite_cmd_master #(
    .P_M_AXI_ADDR_WIDTH(16),
    .P_M_AXI_DATA_WIDTH(32),
    .P_TIMEOUT         (16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_resp     (rsp_resp),
    .timeout      (timeout),
    .m_axi_awaddr (m_axi_awaddr),
    .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata  (m_axi_wdata),
    .m_axi_wvalid (m_axi_wvalid),
    .m_axi_wready (m_axi_wready),
    .m_axi_bresp  (m_axi_bresp),
    .m_axi_bvalid (m_axi_bvalid),
    .m_axi_bready (m_axi_bready),
    .m_axi_araddr (m_axi_araddr),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata  (m_axi_rdata),
    .m_axi_rresp  (m_axi_rresp),
    .m_axi_rvalid (m_axi_rvalid),
    .m_axi_rready (m_axi_rready)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;
  int acc_cyc;

  // Slave configuration, written by the stimulus thread.
  int          aw_delay = 0;
  int          w_delay  = 0;
  int          ar_delay = 0;
  int          r_delay  = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [1:0]  rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = 32'h0;

  // Slave bookkeeping.
  logic [15:0] aw_log[$];
  logic [31:0] w_log[$];
  logic [15:0] ar_log[$];
  logic [15:0] aw_hold, ar_hold;
  logic [31:0] w_hold;
  bit aw_seen, w_seen, ar_seen, aw_pend, w_pend, r_pend, b_fire, r_fire;
  int aw_wait, w_wait, ar_wait, r_wait;
  int b_cnt      = 0;
  int w_first    = 0;
  int drops      = 0;
  int unstable   = 0;
  int rready_gap = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural slave: acts on the falling edge, so a ready raised here is
  // always seen together with the valid at the next rising edge.
  always @(negedge clock) begin
    if (!reset) begin
      m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
      m_axi_bvalid  = 1'b0; m_axi_bresp  = 2'b00;
      m_axi_rvalid  = 1'b0; m_axi_rdata  = 32'h0; m_axi_rresp = 2'b00;
      aw_seen = 0; w_seen = 0; ar_seen = 0; aw_pend = 0; w_pend = 0;
      r_pend  = 0; b_fire = 0; r_fire = 0;
      aw_wait = 0; w_wait = 0; ar_wait = 0; r_wait = 0;
    end else begin
      // Write address
      if (m_axi_awready) begin
        m_axi_awready = 1'b0; aw_log.push_back(aw_hold);
        aw_pend = 1; aw_seen = 0; aw_wait = 0;
      end else if (m_axi_awvalid) begin
        if (!aw_seen) begin aw_seen = 1; aw_hold = m_axi_awaddr; end
        else if (m_axi_awaddr !== aw_hold) unstable++;
        if (aw_wait >= aw_delay) m_axi_awready = 1'b1; else aw_wait++;
      end else if (aw_seen) drops++;
      // Write data
      if (m_axi_wready) begin
        m_axi_wready = 1'b0; w_log.push_back(w_hold);
        if (!aw_pend) w_first++;
        w_pend = 1; w_seen = 0; w_wait = 0;
      end else if (m_axi_wvalid) begin
        if (!w_seen) begin w_seen = 1; w_hold = m_axi_wdata; end
        else if (m_axi_wdata !== w_hold) unstable++;
        if (w_wait >= w_delay) m_axi_wready = 1'b1; else w_wait++;
      end else if (w_seen) drops++;
      // Write response
      if (b_fire) begin m_axi_bvalid = 1'b0; b_fire = 0; b_cnt++; end
      if (aw_pend && w_pend && !m_axi_bvalid) begin
        m_axi_bvalid = 1'b1; m_axi_bresp = bresp_cfg; aw_pend = 0; w_pend = 0;
      end
      if (m_axi_bvalid && m_axi_bready) b_fire = 1;
      // Read address
      if (m_axi_arready) begin
        m_axi_arready = 1'b0; ar_log.push_back(ar_hold);
        r_pend = 1; r_wait = 0; ar_seen = 0; ar_wait = 0;
      end else if (m_axi_arvalid) begin
        if (!ar_seen) begin ar_seen = 1; ar_hold = m_axi_araddr; end
        else if (m_axi_araddr !== ar_hold) unstable++;
        if (ar_wait >= ar_delay) m_axi_arready = 1'b1; else ar_wait++;
      end else if (ar_seen) drops++;
      // Read data
      if (r_fire) begin m_axi_rvalid = 1'b0; r_fire = 0; end
      if (r_pend) begin
        if (!m_axi_rready) rready_gap++;
        if (!m_axi_rvalid) begin
          if (r_wait >= r_delay) begin
            m_axi_rvalid = 1'b1; m_axi_rdata = rdata_cfg; m_axi_rresp = rresp_cfg;
          end else r_wait++;
        end
        if (m_axi_rvalid && m_axi_rready) begin r_fire = 1; r_pend = 0; end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one command as soon as cmd_ready is high; returns just after the
  // accepting edge. acc_cyc marks the acceptance cycle.
  task automatic send_cmd(input logic wr, input logic [15:0] addr, input logic [31:0] data);
    int n = 0;
    while (!cmd_ready && n < 50) begin step(); n++; end
    if (!cmd_ready) check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
    acc_cyc = cyc;
    step();
    cmd_valid = 1'b0;
  endtask

  // Wait for rsp_valid, optionally hold rsp_ready low for `hold` cycles while
  // watching the response stay put, then complete the handshake.
  task automatic wait_rsp(input int hold, output int lat, output logic [31:0] rd,
                          output logic [1:0] rs, output logic to_seen, output int hold_bad);
    int n = 0;
    hold_bad = 0;
    while (!rsp_valid && n < 200) begin step(); n++; end
    lat = cyc - acc_cyc;
    rd = rsp_rdata; rs = rsp_resp; to_seen = timeout;
    if (!rsp_valid) begin
      check("rsp_wait", 64'(rsp_valid), 64'd1);
    end else begin
      for (int i = 0; i < hold; i++) begin
        step();
        if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_resp !== rs || cmd_ready !== 1'b0)
          hold_bad++;
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
    end
  endtask

  initial begin
    int          lat, hb, first_to, arv_low, bad, lat_bad, aw0, w0, wf0;
    logic [31:0] rd;
    logic [1:0]  rs;
    logic        to;

    reset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; rsp_ready = 1'b0;
    repeat (3) step();

    // Reset values
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_axi_ctrl", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                               m_axi_arvalid, m_axi_rready}), 64'd0);
    check("rst_axi_payload", {m_axi_awaddr, m_axi_araddr, m_axi_wdata}, 64'd0);
    check("rst_rsp", 64'({rsp_valid, rsp_resp, rsp_rdata, timeout}), 64'd0);
    reset = 1'b1;
    step();
    check("rel_cmd_ready", 64'(cmd_ready), 64'd1);

    // Zero-wait read
    rdata_cfg = 32'hDEADBEEF;
    send_cmd(1'b0, 16'h0010, 32'h0);
    wait_rsp(0, lat, rd, rs, to, hb);
    check("rd0_latency", 64'(lat), 64'd3);
    check("rd0_rdata", 64'(rd), 64'hDEADBEEF);
    check("rd0_resp", 64'(rs), 64'd0);
    check("rd0_araddr", 64'(ar_log[$]), 64'h0010);

    // Zero-wait write to 0x0008
    send_cmd(1'b1, 16'h0008, 32'h84000032);
    wait_rsp(0, lat, rd, rs, to, hb);
    check("wr0_latency", 64'(lat), 64'd3);
    check("wr0_rdata_zero", 64'(rd), 64'd0);
    check("wr0_resp", 64'(rs), 64'd0);
    check("wr0_awaddr", 64'(aw_log[$]), 64'h0008);
    check("wr0_wdata", 64'(w_log[$]), 64'h84000032);

    // Read with 4 wait cycles on R
    r_delay = 4; rdata_cfg = 32'h00000005;
    send_cmd(1'b0, 16'h0000, 32'h0);
    wait_rsp(0, lat, rd, rs, to, hb);
    check("rd4_rdata", 64'(rd), 64'h5);
    check("rd4_resp", 64'(rs), 64'd0);
    check("rd4_latency", 64'(lat), 64'd7);
    check("rd4_rready_held", 64'(rready_gap), 64'd0);
    r_delay = 0;

    // Eight back-to-back writes, AW delayed by 2 cycles, W immediate
    aw_delay = 2; w_delay = 0;
    aw0 = aw_log.size(); w0 = w_log.size(); wf0 = w_first; lat_bad = 0;
    for (int i = 0; i < 8; i++) begin
      send_cmd(1'b1, 16'h0004, 32'(i + 1));
      wait_rsp(0, lat, rd, rs, to, hb);
      if (lat != 5 || rs !== 2'b00 || rd !== 32'h0) lat_bad++;
    end
    check("b2b_aw_count", 64'(aw_log.size() - aw0), 64'd8);
    check("b2b_w_count", 64'(w_log.size() - w0), 64'd8);
    check("b2b_w_before_aw", 64'(w_first - wf0), 64'd8);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (aw_log.size() > aw0 + i && aw_log[aw0 + i] !== 16'h0004) bad++;
      if (w_log.size() > w0 + i && w_log[w0 + i] !== 32'(i + 1)) bad++;
    end
    check("b2b_order", 64'(bad), 64'd0);
    check("b2b_latency_resp", 64'(lat_bad), 64'd0);
    aw_delay = 0;

    // SLVERR write response with rsp_ready held low for 5 cycles
    bresp_cfg = 2'b10;
    send_cmd(1'b1, 16'h000C, 32'h12345678);
    wait_rsp(5, lat, rd, rs, to, hb);
    check("slverr_resp", 64'(rs), 64'h2);
    check("slverr_rdata", 64'(rd), 64'd0);
    check("slverr_hold_stable", 64'(hb), 64'd0);
    bresp_cfg = 2'b00;

    // Read address stalled 40 cycles against a 16-cycle timeout
    ar_delay = 40; rdata_cfg = 32'h00000777;
    send_cmd(1'b0, 16'h0030, 32'h0);
    first_to = 0; arv_low = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (timeout && first_to == 0) first_to = k;
      if (!m_axi_arvalid) arv_low++;
    end
    check("to_first_cycle", 64'(first_to), 64'd16);
    check("to_arvalid_held", 64'(arv_low), 64'd0);
    wait_rsp(0, lat, rd, rs, to, hb);
    check("to_rdata", 64'(rd), 64'h777);
    check("to_latency", 64'(lat), 64'd43);
    check("to_flag_at_rsp", 64'(to), 64'd1);
    check("to_cleared", 64'(timeout), 64'd0);
    ar_delay = 0;

    // Reset in the middle of a write
    aw_delay = 10; w_delay = 10;
    aw0 = aw_log.size();
    send_cmd(1'b1, 16'h0040, 32'hCAFE0001);
    step();
    check("mid_wvalid", 64'(m_axi_wvalid), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_valids", 64'({m_axi_awvalid, m_axi_wvalid}), 64'd0);
    check("mid_rst_rsp", 64'({rsp_valid, cmd_ready}), 64'd0);
    step();
    step();
    reset = 1'b1;
    step();
    check("mid_rel_cmd_ready", 64'(cmd_ready), 64'd1);
    check("mid_rel_no_rsp", 64'(rsp_valid), 64'd0);
    aw_delay = 0; w_delay = 0; rdata_cfg = 32'h0000A5A5;
    send_cmd(1'b0, 16'h0020, 32'h0);
    wait_rsp(0, lat, rd, rs, to, hb);
    check("post_rst_rdata", 64'(rd), 64'hA5A5);
    check("post_rst_latency", 64'(lat), 64'd3);
    check("post_rst_araddr", 64'(ar_log[$]), 64'h0020);
    check("aborted_aw_not_issued", 64'(aw_log.size() - aw0), 64'd0);

    // Protocol totals over the whole run
    step();
    check("valid_drops", 64'(drops), 64'd0);
    check("payload_stable", 64'(unstable), 64'd0);
    check("total_ar", 64'(ar_log.size()), 64'd4);
    check("total_aw", 64'(aw_log.size()), 64'd10);
    check("total_w", 64'(w_log.size()), 64'd10);
    check("total_b", 64'(b_cnt), 64'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
